// File: rtl/fft_frame_arbiter.sv
// Frame-granular round-robin arbiter that time-shares one serial FFT datapath
// between NCH window sources, running FRAMES_PER_CH frames per channel per trigger.
module fft_frame_arbiter #(
  parameter int NCH           = 4,
  parameter int DW            = 32,
  parameter int FRAME_LEN     = 512,
  parameter int FRAMES_PER_CH = 25
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   trigger,
  input  logic [NCH*DW-1:0]      in_data,
  input  logic [NCH-1:0]         in_last,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  output logic [DW-1:0]          out_data,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(NCH)-1:0] out_chan,
  output logic                   active,
  output logic                   done,
  output logic                   frame_err
);
  localparam int CW  = $clog2(NCH);
  localparam int FCW = $clog2(FRAMES_PER_CH + 1);
  localparam int BCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BCW-1:0] LAST_IDX   = BCW'(FRAME_LEN - 1);
  localparam logic [FCW-1:0] FRAMES_MAX = FCW'(FRAMES_PER_CH);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_grant;
  logic [CW-1:0]  r_rr_ptr;
  logic [FCW-1:0] r_frame_cnt [NCH];
  logic [BCW-1:0] r_beat_cnt;
  logic           r_frame_err;

  logic [NCH-1:0] w_eligible;
  logic           w_any_elig;
  logic           w_hi_found;
  logic [CW-1:0]  w_hi_sel;
  logic [CW-1:0]  w_lo_sel;
  logic [CW-1:0]  w_sel;
  logic [CW-1:0]  w_next_ptr;
  logic           w_xfer;
  logic           w_beat;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_eligible[c] = (r_frame_cnt[c] < FRAMES_MAX);
    end
  end

  assign w_any_elig = |w_eligible;

  // Lowest eligible index at/above rr_ptr wins; otherwise wrap to lowest eligible overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_sel   = '0;
    w_lo_sel   = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (w_eligible[c]) begin
        w_lo_sel = CW'(c);
        if (CW'(c) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_sel   = CW'(c);
        end
      end
    end
    w_sel = w_hi_found ? w_hi_sel : w_lo_sel;
  end

  assign w_next_ptr = (r_grant == CW'(NCH - 1)) ? '0 : r_grant + CW'(1);
  assign w_xfer     = (r_state == S_XFER);

  always_comb begin
    out_data  = '0;
    out_last  = 1'b0;
    out_valid = 1'b0;
    in_ready  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_xfer && (r_grant == CW'(c))) begin
        out_data    = in_data[c*DW +: DW];
        out_last    = in_last[c];
        out_valid   = in_valid[c];
        in_ready[c] = out_ready;
      end
    end
  end

  assign w_beat    = out_valid && out_ready;
  assign out_chan  = r_grant;
  assign active    = (r_state != S_IDLE);
  assign frame_err = r_frame_err;

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: if (trigger) w_state_nxt = S_ARB;
      S_ARB: begin
        if (w_any_elig) begin
          w_state_nxt = S_XFER;
        end else begin
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_XFER: if (w_beat && out_last) w_state_nxt = S_ARB;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_frame_err <= 1'b0;
      for (int c = 0; c < NCH; c++) r_frame_cnt[c] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && trigger) begin
        r_frame_err <= 1'b0;
        for (int c = 0; c < NCH; c++) r_frame_cnt[c] <= '0;
      end
      if ((r_state == S_ARB) && w_any_elig) r_grant <= w_sel;
      if (w_beat) begin
        if (out_last) begin
          for (int c = 0; c < NCH; c++) begin
            if (r_grant == CW'(c)) r_frame_cnt[c] <= r_frame_cnt[c] + FCW'(1);
          end
          r_rr_ptr   <= w_next_ptr;
          r_beat_cnt <= '0;
          if (r_beat_cnt != LAST_IDX) r_frame_err <= 1'b1;
        end else if (r_beat_cnt == LAST_IDX) begin
          // Over-long frame: flag it and hold the count; only tlast ends the frame.
          r_frame_err <= 1'b1;
        end else begin
          r_beat_cnt <= r_beat_cnt + BCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Bench for fft_frame_arbiter: randomized per-channel frame sources checked each
// cycle against a frame-sequence reference (round-robin order, frame-length rule).
module tb_fft_frame_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int FL  = 4;
  localparam int FPC = 2;
  localparam int CW  = $clog2(NCH);

  logic              clk = 1'b0;
  logic              arstn;
  logic              trigger;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_last;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_chan;
  logic              active;
  logic              done;
  logic              frame_err;

  int checks = 0;
  int errors = 0;

  int rdy_mode, vld_pct, late_ch, late_n, abort_ch, trig_mid_cyc;
  int len_tab [NCH][FPC];
  int run_beats, run_cycles, run_done;
  int m_start = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  fft_frame_arbiter #(.NCH(NCH), .DW(DW), .FRAME_LEN(FL), .FRAMES_PER_CH(FPC)) dut (
    .clk(clk), .arstn(arstn), .trigger(trigger), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .active(active),
    .done(done), .frame_err(frame_err)
  );

  task automatic set_defaults();
    rdy_mode = 0; vld_pct = 100; late_ch = -1; late_n = 0; abort_ch = -1; trig_mid_cyc = -1;
    for (int c = 0; c < NCH; c++)
      for (int f = 0; f < FPC; f++) len_tab[c][f] = FL;
  endtask

  // One capture run: sources follow len_tab, expected grant order is plain round-robin.
  task automatic run_capture();
    int q[$];
    int src_pos [NCH];
    int src_frm [NCH];
    int cyc, late_left, ch, b, len;
    bit gap, fin, late_armed;
    logic [NCH-1:0] exp_rdy;
    run_beats = 0; run_cycles = 0; run_done = 0; late_left = 0;
    late_armed = (late_ch >= 0);
    for (int c = 0; c < NCH; c++) begin src_pos[c] = 0; src_frm[c] = 0; end
    for (int i = 0; i < NCH*FPC; i++) q.push_back((m_start + i) % NCH);
    @(posedge clk); #1;
    trigger = 1'b1; out_ready = 1'b1; in_last = '0; in_valid = '1;
    for (int c = 0; c < NCH; c++) in_data[c*DW +: DW] = $urandom;
    #1;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL trig_active got %0b want 0", active); end
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL trig_in_ready got %b want 0000", in_ready); end
    checks++; if (frame_err !== exp_err) begin errors++; $display("FAIL trig_frame_err got %0b want %0b", frame_err, exp_err); end
    exp_err = 1'b0; gap = 1'b1; fin = 1'b0; cyc = 0;
    while (!fin) begin
      @(posedge clk); #1;
      trigger = (cyc == trig_mid_cyc);
      ch = gap ? -1 : q[0];
      for (int c = 0; c < NCH; c++) begin
        in_data[c*DW +: DW] = $urandom;
        in_valid[c] = ($urandom_range(99) < vld_pct);
        len = (src_frm[c] < FPC) ? len_tab[c][src_frm[c]] : FL;
        in_last[c] = (src_pos[c] == len - 1);
      end
      if (!gap && ch == late_ch && late_left > 0) begin in_valid[ch] = 1'b0; late_left--; end
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(1));
      endcase
      if (abort_ch >= 0 && !gap && ch == abort_ch && src_pos[ch] == 1) begin
        in_valid[ch] = 1'b1; out_ready = 1'b1;
        #1 arstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== '0) begin errors++; $display("FAIL rst_mid_in_ready got %b want 0000", in_ready); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_mid_active got %0b want 0", active); end
        checks++; if (out_chan !== '0) begin errors++; $display("FAIL rst_mid_out_chan got %0d want 0", out_chan); end
        checks++; if (done !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got done=%0b err=%0b want 0 0", done, frame_err); end
        m_start = 0; exp_err = 1'b0;
        return;
      end
      #1;
      run_cycles++;
      if (done === 1'b1) run_done++;
      checks++; if (frame_err !== exp_err) begin errors++; $display("FAIL frame_err cyc %0d got %0b want %0b", cyc, frame_err, exp_err); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL active cyc %0d got %0b want 1", cyc, active); end
      if (gap) begin
        checks++; if (out_valid !== 1'b0 || in_ready !== '0) begin errors++; $display("FAIL arb_quiet cyc %0d got valid=%0b ready=%b want 0 0000", cyc, out_valid, in_ready); end
        checks++; if (done !== (q.size() == 0)) begin errors++; $display("FAIL done cyc %0d got %0b want %0b", cyc, done, q.size() == 0); end
        if (q.size() == 0) fin = 1'b1;
        else begin
          gap = 1'b0;
          if (late_armed && q[0] == late_ch) begin late_left = late_n; late_armed = 1'b0; end
        end
      end else begin
        exp_rdy = '0; exp_rdy[ch] = out_ready;
        checks++; if (out_chan !== CW'(ch)) begin errors++; $display("FAIL out_chan cyc %0d got %0d want %0d", cyc, out_chan, ch); end
        checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL in_ready cyc %0d got %b want %b", cyc, in_ready, exp_rdy); end
        checks++; if (out_valid !== in_valid[ch] || out_last !== in_last[ch]) begin errors++;
          $display("FAIL pass_ctl cyc %0d got v=%0b l=%0b want v=%0b l=%0b", cyc, out_valid, out_last, in_valid[ch], in_last[ch]); end
        checks++; if (out_data !== in_data[ch*DW +: DW]) begin errors++; $display("FAIL out_data cyc %0d got %h want %h", cyc, out_data, in_data[ch*DW +: DW]); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_mid cyc %0d got %0b want 0", cyc, done); end
        if (in_valid[ch] && out_ready) begin
          b = src_pos[ch]; run_beats++;
          if ((in_last[ch] && b != FL - 1) || (!in_last[ch] && b >= FL - 1)) exp_err = 1'b1;
          if (in_last[ch]) begin
            src_pos[ch] = 0; src_frm[ch]++; void'(q.pop_front()); gap = 1'b1; m_start = (ch + 1) % NCH;
          end else src_pos[ch]++;
        end
      end
      cyc++;
      if (cyc > 3000) begin
        checks++; errors++; $display("FAIL run_timeout got %0d cycles want done within 3000", cyc);
        return;
      end
    end
    @(posedge clk); #1;
    trigger = 1'b0;
    #1;
    if (done === 1'b1) run_done++;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL post_done_active got %0b want 0", active); end
  endtask

  task automatic test_reset();
    arstn = 1'b0; trigger = 1'b0; in_data = '0; in_last = '0; in_valid = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (in_ready !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_io got ready=%b valid=%0b want 0000 0", in_ready, out_valid); end
    checks++; if (active !== 1'b0 || done !== 1'b0 || frame_err !== 1'b0) begin errors++;
      $display("FAIL reset_flags got a=%0b d=%0b e=%0b want 0 0 0", active, done, frame_err); end
    checks++; if (out_chan !== '0) begin errors++; $display("FAIL reset_out_chan got %0d want 0", out_chan); end
    arstn = 1'b1;
  endtask

  task automatic test_idle_hold();
    in_valid = '1; out_ready = 1'b1; trigger = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) in_data[c*DW +: DW] = $urandom;
      #1;
      checks++; if (in_ready !== '0 || out_valid !== 1'b0 || active !== 1'b0) begin errors++;
        $display("FAIL idle_hold cyc %0d got ready=%b valid=%0b active=%0b want 0000 0 0", i, in_ready, out_valid, active); end
    end
  endtask

  task automatic test_basic_run();
    set_defaults();
    run_capture();
    checks++; if (run_beats != NCH*FPC*FL) begin errors++; $display("FAIL basic_beats got %0d want %0d", run_beats, NCH*FPC*FL); end
    checks++; if (run_done != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", run_done); end
    checks++; if (run_cycles != NCH*FPC*(FL+1) + 1) begin errors++; $display("FAIL basic_cycles got %0d want %0d", run_cycles, NCH*FPC*(FL+1) + 1); end
  endtask

  task automatic test_backpressure();
    set_defaults(); rdy_mode = 1;
    run_capture();
    checks++; if (run_beats != NCH*FPC*FL || run_done != 1) begin errors++; $display("FAIL bp_toggle got beats=%0d done=%0d want %0d 1", run_beats, run_done, NCH*FPC*FL); end
    set_defaults(); rdy_mode = 2; vld_pct = 60;
    run_capture();
    checks++; if (run_beats != NCH*FPC*FL || run_done != 1) begin errors++; $display("FAIL bp_random got beats=%0d done=%0d want %0d 1", run_beats, run_done, NCH*FPC*FL); end
  endtask

  task automatic test_late_channel();
    set_defaults(); late_ch = 1; late_n = 20;
    run_capture();
    checks++; if (run_cycles != NCH*FPC*(FL+1) + 1 + 20) begin errors++; $display("FAIL late_cycles got %0d want %0d", run_cycles, NCH*FPC*(FL+1) + 21); end
    checks++; if (run_beats != NCH*FPC*FL) begin errors++; $display("FAIL late_beats got %0d want %0d", run_beats, NCH*FPC*FL); end
  endtask

  task automatic test_length_violation();
    set_defaults(); len_tab[2][0] = 3;
    run_capture();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_frame_err got %0b want 1", frame_err); end
    checks++; if (run_beats != NCH*FPC*FL - 1) begin errors++; $display("FAIL short_beats got %0d want %0d", run_beats, NCH*FPC*FL - 1); end
    set_defaults(); len_tab[1][1] = 5;
    run_capture();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL long_frame_err got %0b want 1", frame_err); end
    checks++; if (run_beats != NCH*FPC*FL + 1) begin errors++; $display("FAIL long_beats got %0d want %0d", run_beats, NCH*FPC*FL + 1); end
    set_defaults();
    run_capture();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL clean_frame_err got %0b want 0", frame_err); end
  endtask

  task automatic test_trigger_mid();
    set_defaults(); trig_mid_cyc = 10;
    run_capture();
    checks++; if (run_beats != NCH*FPC*FL || run_done != 1) begin errors++; $display("FAIL trig_mid got beats=%0d done=%0d want %0d 1", run_beats, run_done, NCH*FPC*FL); end
  endtask

  task automatic test_reset_mid();
    set_defaults(); abort_ch = 3;
    run_capture();
    @(posedge clk); #2;
    arstn = 1'b1; trigger = 1'b0;
    set_defaults();
    run_capture();
    checks++; if (run_beats != NCH*FPC*FL || run_done != 1) begin errors++; $display("FAIL after_reset got beats=%0d done=%0d want %0d 1", run_beats, run_done, NCH*FPC*FL); end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_basic_run();
    test_backpressure();
    test_late_channel();
    test_length_violation();
    test_trigger_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
- Shares the single serial FFT/abs-value datapath between NCH microphone window sources.
- Grants whole frames, never individual beats. A grant is held from the first beat of a frame through its tlast beat.
- Uses round-robin selection among channels that still owe frames.
- Sequences one capture run per trigger: FRAMES_PER_CH frames per channel, then signals done and returns to idle.

Parameters:
- NCH, 4, number of requesting channels (>=2).
- DW, 32, beat data width (complex sample, 16b real + 16b imag).
- FRAME_LEN, 512, beats per frame (FFT length).
- FRAMES_PER_CH, 25, frames each channel delivers per run.

Ports:
- clk  in  1  clock.
- arstn  in  1  asynchronous active-low reset.
- trigger  in  1  starts a run; sampled only in IDLE.
- in_data  in  NCH*DW  channel c occupies bits [c*DW +: DW].
- in_last  in  NCH  per-channel frame-end flag.
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready.
- out_data  out  DW  granted channel data.
- out_last  out  1  granted channel last.
- out_valid  out  1  granted channel valid.
- out_ready  in  1  downstream (FFT) ready.
- out_chan  out  $clog2(NCH)  index of granted channel, held for the whole frame.
- active  out  1  high in ARB and XFER.
- done  out  1  one-cycle pulse at end of run.
- frame_err  out  1  sticky flag for a frame-length violation.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0.
  - All frame counters and the beat counter = 0.
  - out_valid=0, in_ready=0, done=0, frame_err=0, active=0.
- States:
  - IDLE -> ARB on trigger. frame_err and all per-channel frame counters clear on this same edge.
  - ARB, one cycle:
    - Eligible = channel frame count < FRAMES_PER_CH.
    - Grant = first eligible channel searching upward from rr_ptr, with wrap.
    - Grant is registered -> XFER.
    - If no channel is eligible: done pulses for one cycle -> IDLE.
    - in_valid is not a grant condition; a granted channel may start its frame late.
  - XFER:
    - out_data = in_data[grant]; out_last = in_last[grant]; out_valid = in_valid[grant].
    - in_ready[grant] = out_ready; all other in_ready = 0.
    - Zero-latency combinational pass-through.
    - A beat is a cycle with out_valid && out_ready.
    - On a beat with out_last: frame count[grant] += 1, rr_ptr <= grant+1 (mod NCH), beat counter <= 0, -> ARB.
- Idle outputs: in IDLE and ARB, out_valid=0 and in_ready=0 (no data accepted).
- Beat counter:
  - Increments on each non-last beat.
  - A last beat with counter != FRAME_LEN-1 sets frame_err.
  - A non-last beat with counter == FRAME_LEN-1 also sets frame_err. The counter then saturates; the frame still ends only on last.
- Trigger handling: trigger outside IDLE is ignored.
- done: asserted only in the ARB cycle that finds no eligible channel. Next state is IDLE.
- active: = (state != IDLE). It drops in the cycle after the done pulse.
- Frame counters: width $clog2(FRAMES_PER_CH+1); no wrap.
- Reset mid-run: returns immediately to the reset values. A partial frame is abandoned and downstream must be reset together with this block.
- Backpressure: out_ready low stalls the granted channel only. The grant never changes mid-frame.

Test Plan:
- Reset with NCH=4, FRAME_LEN=4, FRAMES_PER_CH=2:
  - Hold all in_valid=1 and out_ready=1, no trigger -> in_ready=0000, out_valid=0, active=0 indefinitely.
  - Pulse trigger -> out_chan sequence 0,1,2,3,0,1,2,3, each granted for exactly 4 beats.
  - done pulses once, 1 cycle after the 32nd beat; active=0 on the following cycle.
- Round-robin under backpressure:
  - Toggle out_ready 1010… -> each frame still takes 4 beats with out_chan constant.
  - Non-granted in_ready stay 0; the order is unchanged.
- Late channel:
  - Channel 1 in_valid=0 for 20 cycles after its grant -> out_valid=0 and the grant holds on channel 1.
  - Channels 2 and 3 are not served until channel 1 completes its frame.
- Length violations:
  - Channel 2 asserts last on its 3rd beat -> frame_err=1 and stays set.
  - Second trigger after done -> frame_err=0.
  - 5 beats with last on the 5th -> frame_err=1.
- Trigger while active: pulse trigger mid-run -> no effect; total beats remain 32 and done pulses once.
- Reset mid-frame: arstn low during channel 3's 2nd beat -> all outputs return to reset values in the same cycle; a new trigger starts at out_chan=0.
